l2_channel_router: RTL and testbench



---
 rtl/cachepool_pkg.sv | 60 ++++++
 rtl/fifo_v3.sv | 63 ++++++
 rtl/l2_channel_router.sv | 74 +++++++
 tb/tb_l2_channel_router.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepool_pkg.sv
// Shared refill-bus types, default L2 geometry and the channel address scrambler.
package cachepool_pkg;

    localparam int unsigned NumL2Channel  = 4;
    localparam int unsigned L2BankBeWidth = 64;
    localparam int unsigned Interleave    = 16;
    localparam int unsigned DramPerChSize = 32'h1000_0000;

    localparam int unsigned L2AddrWidth = 32;
    localparam int unsigned L2DataWidth = L2BankBeWidth * 8;
    localparam int unsigned L2StrbWidth = L2BankBeWidth;
    localparam int unsigned L2UserWidth = 4;

    typedef struct packed {
        logic [L2AddrWidth-1:0] addr;
        logic                   write;
        logic [L2DataWidth-1:0] data;
        logic [L2StrbWidth-1:0] strb;
        logic [L2UserWidth-1:0] user;
    } l2_req_payload_t;

    typedef struct packed {
        logic [L2DataWidth-1:0] data;
        logic [L2UserWidth-1:0] user;
    } l2_rsp_payload_t;

    typedef struct packed {
        l2_req_payload_t q;
        logic            q_valid;
        logic            p_ready;
    } l2_req_t;

    typedef struct packed {
        l2_rsp_payload_t p;
        logic            p_valid;
        logic            q_ready;
    } l2_rsp_t;

    // Moves the S channel bits at C up to the per-channel size boundary Soff.
    function automatic logic [L2AddrWidth-1:0] scrambleAddr(
        input logic [L2AddrWidth-1:0] addr,
        input int unsigned            c,
        input int unsigned            s,
        input int unsigned            soff
    );
        logic [63:0] a, lo_m, mid_m, ch_m, up_m, res;
        a = 64'(addr);
        if (c < soff) begin
            lo_m  = (64'd1 << c) - 64'd1;
            mid_m = ((64'd1 << soff) - 64'd1) & ~lo_m;
            ch_m  = ((64'd1 << (soff + s)) - 64'd1) & ~((64'd1 << soff) - 64'd1);
            up_m  = ~((64'd1 << (soff + s)) - 64'd1);
            res   = (a & (lo_m | up_m)) | ((a >> s) & mid_m) | ((a << (soff - c)) & ch_m);
        end else begin
            res = a;
        end
        return L2AddrWidth'(res);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Pointer-based FIFO with occupancy count; flush and reset both empty it synchronously.
module fifo_v3 #(
    parameter int unsigned DataWidth = 2,
    parameter int unsigned Depth     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   usage_o,
    input  logic [DataWidth-1:0]     data_i,
    input  logic                     push_i,
    output logic [DataWidth-1:0]     data_o,
    input  logic                     pop_i
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 push_c, pop_c;

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign push_c  = push_i && !full_o;
    assign pop_c   = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_c) wptr_d = wptr_q + PtrWidth'(1);
        if (pop_c)  rptr_d = rptr_q + PtrWidth'(1);
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_c) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/l2_channel_router.sv
// Routes L1 refill requests to interleaved L2 channels and re-serialises responses in order.
// Optional feature: define L2_ADDR_SCRAMBLE_EN to forward channel-local (scrambled) addresses.
module l2_channel_router
    import cachepool_pkg::l2_req_t, cachepool_pkg::l2_rsp_t, cachepool_pkg::scrambleAddr;
#(
    parameter int unsigned NumChannels    = cachepool_pkg::NumL2Channel,
    parameter int unsigned AddrWidth      = cachepool_pkg::L2AddrWidth,
    parameter int unsigned BankBeWidth    = cachepool_pkg::L2BankBeWidth,
    parameter int unsigned Interleave     = cachepool_pkg::Interleave,
    parameter int unsigned DramPerChSize  = cachepool_pkg::DramPerChSize,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  l2_req_t                           req_i,
    output l2_rsp_t                           rsp_o,
    output l2_req_t                           ch_req_o [NumChannels],
    input  l2_rsp_t                           ch_rsp_i [NumChannels],
    output logic [$clog2(MaxOutstanding):0]   outstanding_o
);

    localparam int unsigned C    = $clog2(BankBeWidth * Interleave);
    localparam int unsigned S    = $clog2(NumChannels);
    localparam int unsigned Soff = $clog2(DramPerChSize);

    logic [S-1:0]         sel_c, head_c;
    logic [AddrWidth-1:0] fwd_addr_c;
    logic                 full_c, empty_c, push_c, pop_c;

    assign sel_c = req_i.q.addr[C+S-1:C];

`ifdef L2_ADDR_SCRAMBLE_EN
    assign fwd_addr_c = scrambleAddr(req_i.q.addr, C, S, Soff);
`else
    assign fwd_addr_c = req_i.q.addr;
`endif

    // Payload is broadcast; only the selected / head channel sees the handshake.
    always_comb begin
        for (int unsigned i = 0; i < NumChannels; i++) begin
            ch_req_o[i]         = req_i;
            ch_req_o[i].q.addr  = fwd_addr_c;
            ch_req_o[i].q_valid = req_i.q_valid && !full_c && (sel_c == S'(i));
            ch_req_o[i].p_ready = req_i.p_ready && !empty_c && (head_c == S'(i));
        end
    end

    always_comb begin
        rsp_o         = '0;
        rsp_o.p       = ch_rsp_i[head_c].p;
        rsp_o.p_valid = !empty_c && ch_rsp_i[head_c].p_valid;
        rsp_o.q_ready = ch_rsp_i[sel_c].q_ready && !full_c;
    end

    assign push_c = req_i.q_valid && rsp_o.q_ready;
    assign pop_c  = rsp_o.p_valid && req_i.p_ready;

    fifo_v3 #(
        .DataWidth (S),
        .Depth     (MaxOutstanding)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (rst_i),
        .full_o  (full_c),
        .empty_o (empty_c),
        .usage_o (outstanding_o),
        .data_i  (sel_c),
        .push_i  (push_c),
        .data_o  (head_c),
        .pop_i   (pop_c)
    );

endmodule

// File: tb/tb_l2_channel_router.sv
// Self-checking bench for l2_channel_router: directed scenarios plus a randomized run against an in-order queue model.
module tb_l2_channel_router;
    import cachepool_pkg::*;

    localparam int unsigned NCh   = NumL2Channel;
    localparam int unsigned Block = L2BankBeWidth * Interleave;
    localparam int unsigned Depth = 8;

    logic    clk = 1'b0;
    logic    rst;
    l2_req_t req;
    l2_rsp_t rsp;
    l2_req_t ch_req [NCh];
    l2_rsp_t ch_rsp [NCh];
    logic [3:0] outstanding;

    int tests_run    = 0;
    int tests_failed = 0;
    int route_q[$];

    always #5 clk = ~clk;

    l2_channel_router #(.MaxOutstanding(Depth)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .rsp_o         (rsp),
        .ch_req_o      (ch_req),
        .ch_rsp_i      (ch_rsp),
        .outstanding_o (outstanding)
    );

    function automatic int chan_of(input logic [31:0] a);
        return int'((64'(a) / 64'(Block)) % 64'(NCh));
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
        longint unsigned v, blk, csz, nch, res;
        v = 64'(a); blk = 64'(Block); csz = 64'(DramPerChSize); nch = 64'(NCh);
        res = v;
`ifdef L2_ADDR_SCRAMBLE_EN
        if (blk < csz)
            res = (v / (csz * nch)) * csz * nch + ((v / blk) % nch) * csz
                + ((v / (blk * nch)) % (csz / blk)) * blk + v % blk;
`endif
        return res[31:0];
    endfunction

    function automatic int count_ch(input int c);
        int n = 0;
        foreach (route_q[k]) if (route_q[k] == c) n++;
        return n;
    endfunction

    task automatic rand_payload(output l2_req_payload_t p);
        for (int k = 0; k < L2DataWidth / 32; k++) p.data[k*32 +: 32] = $urandom;
        p.addr  = $urandom;
        p.write = 1'($urandom_range(0, 1));
        p.strb  = {$urandom, $urandom};
        p.user  = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_data(output logic [L2DataWidth-1:0] d);
        for (int k = 0; k < L2DataWidth / 32; k++) d[k*32 +: 32] = $urandom;
    endtask

    task automatic idle();
        req = '0;
        for (int i = 0; i < NCh; i++) begin
            ch_rsp[i] = '0;
            ch_rsp[i].q_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        route_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        req.p_ready = 1'b1;
        for (int i = 0; i < NCh; i++) ch_rsp[i].p_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", outstanding); end
        tests_run++; if (rsp.p_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_p_valid: got %b want 0", rsp.p_valid); end
        for (int i = 0; i < NCh; i++) begin
            tests_run++; if (ch_req[i].p_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_p_ready ch%0d: got %b want 0", i, ch_req[i].p_ready); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        l2_req_payload_t p;
        logic [L2DataWidth-1:0] d;
        do_reset();
        rand_payload(p);
        p.addr = 32'h8000_0C00;
        req.q = p; req.q_valid = 1'b1;
        #1;
        for (int i = 0; i < NCh; i++) begin
            tests_run++; if (ch_req[i].q_valid !== (i == 3)) begin tests_failed++; $display("FAIL single_q_valid ch%0d: got %b want %b", i, ch_req[i].q_valid, (i == 3)); end
        end
        tests_run++; if (rsp.q_ready !== 1'b1) begin tests_failed++; $display("FAIL single_q_ready: got %b want 1", rsp.q_ready); end
        tests_run++; if (ch_req[0].q.data !== p.data || ch_req[0].q.strb !== p.strb) begin tests_failed++; $display("FAIL single_broadcast: payload not forwarded to ch0"); end
        @(negedge clk);
        rand_data(d);
        req.q_valid = 1'b0; req.p_ready = 1'b1;
        ch_rsp[3].p_valid = 1'b1; ch_rsp[3].p.data = d;
        #1;
        tests_run++; if (outstanding !== 4'd1) begin tests_failed++; $display("FAIL single_level1: got %0d want 1", outstanding); end
        tests_run++; if (rsp.p_valid !== 1'b1) begin tests_failed++; $display("FAIL single_p_valid: got %b want 1", rsp.p_valid); end
        tests_run++; if (rsp.p.data !== d) begin tests_failed++; $display("FAIL single_p_data: got %h want %h", rsp.p.data, d); end
        tests_run++; if (ch_req[3].p_ready !== 1'b1) begin tests_failed++; $display("FAIL single_p_ready: got %b want 1", ch_req[3].p_ready); end
        @(negedge clk);
        ch_rsp[3].p_valid = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL single_level0: got %0d want 0", outstanding); end
    endtask

    task automatic test_scramble();
        logic [31:0] want_a, want_b;
`ifdef L2_ADDR_SCRAMBLE_EN
        want_a = 32'hB000_0000; want_b = 32'h148D_1678;
`else
        want_a = 32'h8000_0C00; want_b = 32'h1234_5678;
`endif
        do_reset();
        req.q.addr = 32'h8000_0C00; req.q_valid = 1'b1; ch_rsp[3].q_ready = 1'b0;
        #1;
        tests_run++; if (ch_req[3].q.addr !== want_a) begin tests_failed++; $display("FAIL scramble_a: got %h want %h", ch_req[3].q.addr, want_a); end
        tests_run++; if (ch_req[3].q_valid !== 1'b1) begin tests_failed++; $display("FAIL scramble_sel_a: got %b want 1", ch_req[3].q_valid); end
        @(negedge clk);
        req.q.addr = 32'h1234_5678; ch_rsp[1].q_ready = 1'b0;
        #1;
        tests_run++; if (ch_req[1].q.addr !== want_b) begin tests_failed++; $display("FAIL scramble_b: got %h want %h", ch_req[1].q.addr, want_b); end
        tests_run++; if (ch_req[1].q_valid !== 1'b1) begin tests_failed++; $display("FAIL scramble_sel_b: got %b want 1", ch_req[1].q_valid); end
    endtask

    task automatic test_reorder();
        logic [L2DataWidth-1:0] d0, d1;
        do_reset();
        rand_data(d0); rand_data(d1);
        req.q.addr = 32'h8000_0000; req.q_valid = 1'b1;
        @(negedge clk);
        req.q.addr = 32'h8000_0400;
        @(negedge clk);
        req.q_valid = 1'b0; req.p_ready = 1'b1;
        ch_rsp[1].p_valid = 1'b1; ch_rsp[1].p.data = d1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (rsp.p_valid !== 1'b0) begin tests_failed++; $display("FAIL reorder_stall_valid c%0d: got %b want 0", k, rsp.p_valid); end
            tests_run++; if (ch_req[1].p_ready !== 1'b0) begin tests_failed++; $display("FAIL reorder_stall_ready c%0d: got %b want 0", k, ch_req[1].p_ready); end
            @(negedge clk);
        end
        ch_rsp[0].p_valid = 1'b1; ch_rsp[0].p.data = d0;
        #1;
        tests_run++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== d0) begin tests_failed++; $display("FAIL reorder_first: got v=%b %h want v=1 %h", rsp.p_valid, rsp.p.data, d0); end
        @(negedge clk);
        ch_rsp[0].p_valid = 1'b0;
        #1;
        tests_run++; if (rsp.p_valid !== 1'b1 || rsp.p.data !== d1) begin tests_failed++; $display("FAIL reorder_second: got v=%b %h want v=1 %h", rsp.p_valid, rsp.p.data, d1); end
        tests_run++; if (ch_req[1].p_ready !== 1'b1) begin tests_failed++; $display("FAIL reorder_p_ready1: got %b want 1", ch_req[1].p_ready); end
        @(negedge clk);
        ch_rsp[1].p_valid = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL reorder_level: got %0d want 0", outstanding); end
    endtask

    task automatic test_full();
        int chans[Depth];
        int s9;
        do_reset();
        for (int k = 0; k < Depth; k++) begin
            req.q.addr = $urandom; req.q_valid = 1'b1;
            chans[k] = chan_of(req.q.addr);
            @(negedge clk);
        end
        req.q.addr = $urandom; s9 = chan_of(req.q.addr);
        ch_rsp[chans[0]].p_valid = 1'b1; req.p_ready = 1'b1;
        #1;
        tests_run++; if (outstanding !== 4'd8) begin tests_failed++; $display("FAIL full_level: got %0d want 8", outstanding); end
        tests_run++; if (rsp.q_ready !== 1'b0) begin tests_failed++; $display("FAIL full_q_ready: got %b want 0", rsp.q_ready); end
        tests_run++; if (ch_req[s9].q_valid !== 1'b0) begin tests_failed++; $display("FAIL full_ch_q_valid: got %b want 0", ch_req[s9].q_valid); end
        tests_run++; if (rsp.p_valid !== 1'b1) begin tests_failed++; $display("FAIL full_pop_valid: got %b want 1", rsp.p_valid); end
        @(negedge clk);
        ch_rsp[chans[0]].p_valid = 1'b0; req.p_ready = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd7) begin tests_failed++; $display("FAIL full_after_pop: got %0d want 7", outstanding); end
        tests_run++; if (rsp.q_ready !== 1'b1) begin tests_failed++; $display("FAIL full_retry_ready: got %b want 1", rsp.q_ready); end
        @(negedge clk);
        req.q_valid = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd8) begin tests_failed++; $display("FAIL full_refill: got %0d want 8", outstanding); end
        for (int k = 1; k < Depth; k++) chans[k-1] = chans[k];
        chans[Depth-1] = s9;
        req.p_ready = 1'b1;
        for (int i = 0; i < NCh; i++) begin
            ch_rsp[i].p_valid = 1'b1;
            ch_rsp[i].p.data  = L2DataWidth'(i + 16);
        end
        for (int k = 0; k < Depth; k++) begin
            #1;
            tests_run++; if (rsp.p.data !== L2DataWidth'(chans[k] + 16)) begin tests_failed++; $display("FAIL full_drain_order %0d: got %0d want %0d", k, rsp.p.data[7:0], chans[k] + 16); end
            @(negedge clk);
        end
        idle();
        #1;
        tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL full_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_backpressure();
        l2_req_payload_t p;
        do_reset();
        rand_payload(p);
        p.addr = 32'h8000_0800;
        req.q = p; req.q_valid = 1'b1; ch_rsp[2].q_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (rsp.q_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_q_ready c%0d: got %b want 0", k, rsp.q_ready); end
            tests_run++; if (ch_req[2].q_valid !== 1'b1 || ch_req[2].q.data !== p.data) begin tests_failed++; $display("FAIL bp_hold c%0d: valid=%b", k, ch_req[2].q_valid); end
            tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL bp_level c%0d: got %0d want 0", k, outstanding); end
            @(negedge clk);
        end
        ch_rsp[2].q_ready = 1'b1;
        #1;
        tests_run++; if (rsp.q_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_rise: got %b want 1", rsp.q_ready); end
        @(negedge clk);
        req.q_valid = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd1) begin tests_failed++; $display("FAIL bp_accepted: got %0d want 1", outstanding); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req.q.addr = 32'h8000_0000; req.q_valid = 1'b1;
        repeat (3) @(negedge clk);
        req.q_valid = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd3) begin tests_failed++; $display("FAIL midrst_level3: got %0d want 3", outstanding); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL midrst_flush: got %0d want 0", outstanding); end
        ch_rsp[0].p_valid = 1'b1; req.p_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests_run++; if (rsp.p_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_late_valid c%0d: got %b want 0", k, rsp.p_valid); end
            tests_run++; if (ch_req[0].p_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_late_ready c%0d: got %b want 0", k, ch_req[0].p_ready); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_random();
        l2_req_payload_t pend;
        bit pend_v = 0;
        bit rv [NCh];
        logic [L2DataWidth-1:0] rd [NCh];
        logic [NCh-1:0] got_qv, exp_qv, got_pr, exp_pr;
        int sel, head;
        bit full, empty, exp_qr, exp_pv, accept, pop;
        do_reset();
        foreach (rv[i]) begin rv[i] = 0; rd[i] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend_v && $urandom_range(0, 2) != 0) begin
                rand_payload(pend);
                pend_v = 1;
            end
            req.q = pend; req.q_valid = pend_v;
            req.p_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCh; i++) begin
                ch_rsp[i].q_ready = ($urandom_range(0, 3) != 0);
                if (!rv[i] && count_ch(i) > 0 && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1;
                    rand_data(rd[i]);
                end
                ch_rsp[i].p_valid = rv[i];
                ch_rsp[i].p.data  = rd[i];
            end
            #1;
            sel    = chan_of(pend.addr);
            full   = (route_q.size() == Depth);
            empty  = (route_q.size() == 0);
            head   = empty ? 0 : route_q[0];
            exp_qr = ch_rsp[sel].q_ready && !full;
            accept = pend_v && exp_qr;
            exp_pv = !empty && rv[head];
            pop    = exp_pv && req.p_ready;
            for (int i = 0; i < NCh; i++) begin
                exp_qv[i] = pend_v && !full && (i == sel);
                exp_pr[i] = req.p_ready && !empty && (i == head);
                got_qv[i] = ch_req[i].q_valid;
                got_pr[i] = ch_req[i].p_ready;
            end
            tests_run++; if (outstanding !== 4'(route_q.size())) begin tests_failed++; $display("FAIL rand_level c%0d: got %0d want %0d", cyc, outstanding, route_q.size()); end
            tests_run++; if (rsp.q_ready !== exp_qr) begin tests_failed++; $display("FAIL rand_q_ready c%0d: got %b want %b", cyc, rsp.q_ready, exp_qr); end
            tests_run++; if (got_qv !== exp_qv) begin tests_failed++; $display("FAIL rand_q_valid c%0d: got %b want %b", cyc, got_qv, exp_qv); end
            tests_run++; if (got_pr !== exp_pr) begin tests_failed++; $display("FAIL rand_p_ready c%0d: got %b want %b", cyc, got_pr, exp_pr); end
            tests_run++; if (rsp.p_valid !== exp_pv) begin tests_failed++; $display("FAIL rand_p_valid c%0d: got %b want %b", cyc, rsp.p_valid, exp_pv); end
            if (exp_pv) begin
                tests_run++; if (rsp.p.data !== rd[head]) begin tests_failed++; $display("FAIL rand_p_data c%0d: got %h want %h", cyc, rsp.p.data, rd[head]); end
            end
            if (pend_v) begin
                tests_run++; if (ch_req[sel].q.addr !== exp_addr(pend.addr)) begin tests_failed++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, ch_req[sel].q.addr, exp_addr(pend.addr)); end
            end
            if (pop) begin
                rv[head] = 0;
                void'(route_q.pop_front());
            end
            if (accept) begin
                route_q.push_back(sel);
                pend_v = 0;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_scramble();
        test_reorder();
        test_full();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
